fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Run-control and program-counter sequencer for the IF stage of the MIPS/DLX pipeline. It owns the PC register, drives the instruction-memory address and read enable, and selects between sequential, branch and jump next-PC. It applies hazard stalls, flushes IF/ID on redirects, supports single-step debug, and drains and halts the pipeline when a HALT instruction is fetched.

## Interface
- ADDR_WIDTH, 10, instruction-memory word-address width
- DATA_WIDTH, 32, instruction width
- HALT_OPCODE, 6'b111111, opcode (bits [31:26]) that stops fetching
- DRAIN_CYCLES, 4, cycles allowed for in-flight instructions to retire after HALT
- RESET_PC, 0, PC value after reset

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  pulse: leave IDLE and begin fetching
- step_mode  in  1  when 1, advance one instruction per step pulse
- step  in  1  single-step pulse, sampled only in WAIT_STEP
- stall  in  1  hazard-unit request to hold PC and IF/ID
- branch_taken  in  1  EX-stage branch resolved taken
- branch_address  in  ADDR_WIDTH  branch target
- jump_taken  in  1  ID-stage jump
- jump_address  in  ADDR_WIDTH  jump target
- instruc_in  in  DATA_WIDTH  instruction-memory read data, valid one cycle after address
- PC  out  ADDR_WIDTH  instruction-memory address
- PC_plus_1  out  ADDR_WIDTH  PC+1 (mod 2^ADDR_WIDTH), forwarded to IF/ID
- imem_enable  out  1  instruction-memory read enable
- pipe_enable  out  1  IF/ID write enable
- flush_IF_ID  out  1  clear IF/ID to NOP this cycle
- halted  out  1  HALTED state reached
- state  out  3  current FSM state (debug)
- instr_count  out  32  instructions fetched and accepted since reset

## Operation
- States: IDLE, RUN, WAIT_STEP, DRAIN, HALTED.
- IDLE: PC=RESET_PC, imem_enable=0, pipe_enable=0. start -> RUN if step_mode=0, else WAIT_STEP.
- RUN: imem_enable=1. PC is updated each cycle by the next-PC rule below. If step_mode is raised, go to WAIT_STEP at the next boundary.
- WAIT_STEP: PC held, pipe_enable=0. A step pulse gives exactly one RUN-equivalent cycle and then returns to WAIT_STEP. If step_mode drops, go to RUN.
- Next-PC priority, high to low:
  - branch_taken: PC<=branch_address. It is older than the jump, so it wins over jump_taken.
  - jump_taken: PC<=jump_address.
  - stall: PC held.
  - otherwise: PC<=PC_plus_1.
- Redirect plus stall in the same cycle: the redirect wins and the stall is ignored, because the stalled instruction is squashed.
- flush_IF_ID=1 in the cycle a redirect is applied, which kills the wrongly fetched instruction.
- PC wraps from 2^ADDR_WIDTH-1 to 0 with no error.
- HALT detection: when instruc_in[31:26]==HALT_OPCODE, the word is valid and it is not being flushed:
  - enter DRAIN;
  - stop incrementing PC;
  - set flush_IF_ID so the HALT itself never enters ID.
- DRAIN: imem_enable=0. Counts DRAIN_CYCLES, then goes to HALTED. A branch_taken during DRAIN is ignored.
- HALTED: halted=1, all enables 0. Exits only on reset.
- instr_count increments on every cycle with pipe_enable=1 and flush_IF_ID=0. It saturates at 2^32-1.

## Timing
- Reset (async) values: state=IDLE, PC=RESET_PC, PC_plus_1=RESET_PC+1, imem_enable=0, pipe_enable=0, flush_IF_ID=0, halted=0, instr_count=0.
- Reset asserted mid-operation clears every register immediately, with no drain.
- PC is registered; PC_plus_1 is combinational from PC.
- Memory latency is 1: the instruction for PC issued in cycle n is checked in cycle n+1.
- pipe_enable = (RUN or stepping cycle) and not stall. flush_IF_ID is combinational from the redirect and HALT conditions.
- start or step pulses outside their accepting state are ignored.
- From start to the first PC advance is one cycle.
- From HALT detection to halted=1 is DRAIN_CYCLES+1 cycles.

## Structure
- A shared package `dlx_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, WAIT_STEP=2, DRAIN=3, HALTED=4);
  - the HALT_OPCODE and NOP constants;
  - the ADDR_WIDTH default.
- One sub-module, `next_pc_mux`: combinational priority select of branch, jump, hold and increment.
- The FSM, counters and PC register live in the top module.

## Test plan
- Reset then start, no stalls, memory returns NOPs: PC goes 0,1,2,3 on consecutive cycles and instr_count=3 after 4 cycles.
- At PC=5, stall held for 2 cycles: PC stays 5 for 2 cycles, pipe_enable=0, then PC moves to 6.
- In one cycle, branch_taken to 0x040, jump_taken to 0x100 and stall all assert: PC<=0x040 and flush_IF_ID=1 for that cycle.
- Start PC at 0x3FF with no redirect: next PC=0x000 and PC_plus_1 shows 0x001.
- HALT word fetched at PC=7: DRAIN for 4 cycles, then halted=1 with imem_enable=0 and the PC frozen; a later start is ignored.
- step_mode=1 with three step pulses spaced 5 cycles apart: PC advances by exactly 1 per pulse, ending at 3. Asserting reset mid-sequence returns state=IDLE and PC=0 immediately.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared DLX pipeline constants: run-control state encoding, HALT/NOP words
// and the default instruction-memory address width.
package dlx_pkg;

  localparam int DLX_ADDR_WIDTH = 10;
  localparam int DLX_DATA_WIDTH = 32;

  localparam logic [5:0]  DLX_HALT_OPCODE = 6'b111111;
  localparam logic [31:0] DLX_NOP         = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RUN       = 3'd1;
  localparam logic [2:0] ST_WAIT_STEP = 3'd2;
  localparam logic [2:0] ST_DRAIN     = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'd0,
    PC_SEL_HOLD   = 2'd1,
    PC_SEL_JUMP   = 2'd2,
    PC_SEL_BRANCH = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// IF-stage bus: instruction-memory port plus the hazard/redirect controls
// exchanged between the fetch sequencer and the rest of the pipeline.
interface fetch_sequencer_if
#(
  parameter int ADDR_WIDTH = dlx_pkg::DLX_ADDR_WIDTH,
  parameter int DATA_WIDTH = dlx_pkg::DLX_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] PC;
  logic [ADDR_WIDTH-1:0] PC_plus_1;
  logic                  imem_enable;
  logic [DATA_WIDTH-1:0] instruc_in;

  logic                  pipe_enable;
  logic                  flush_IF_ID;
  logic                  stall;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_address;
  logic                  jump_taken;
  logic [ADDR_WIDTH-1:0] jump_address;

  modport master (
    output PC, PC_plus_1, imem_enable, pipe_enable, flush_IF_ID,
    input  instruc_in, stall, branch_taken, branch_address, jump_taken, jump_address
  );

  modport slave (
    input  PC, PC_plus_1, imem_enable, pipe_enable, flush_IF_ID,
    output instruc_in, stall, branch_taken, branch_address, jump_taken, jump_address
  );

endinterface

// File: rtl/next_pc_mux.sv
// Next-PC priority select: branch (oldest) over jump over hold over increment.
module next_pc_mux
  import dlx_pkg::*;
#(
  parameter int ADDR_WIDTH = DLX_ADDR_WIDTH
) (
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_address,
  input  logic                  jump_taken,
  input  logic [ADDR_WIDTH-1:0] jump_address,
  input  logic                  hold,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] pc_plus_1,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  pc_sel_e sel;

  // A redirect outranks hold: the stalled instruction is squashed anyway.
  always_comb begin
    sel = PC_SEL_INC;
    if (branch_taken)    sel = PC_SEL_BRANCH;
    else if (jump_taken) sel = PC_SEL_JUMP;
    else if (hold)       sel = PC_SEL_HOLD;
  end

  always_comb begin
    pc_next = pc_plus_1;
    case (sel)
      PC_SEL_BRANCH: pc_next = branch_address;
      PC_SEL_JUMP:   pc_next = jump_address;
      PC_SEL_HOLD:   pc_next = pc;
      default:       pc_next = pc_plus_1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage run control: owns the PC, issues instruction fetches, applies
// stalls and redirects, single-steps, and drains the pipe after a HALT.
//
// state      | meaning
// IDLE       | PC parked at RESET_PC, no fetch, waiting for start
// RUN        | fetch every cycle, PC follows the next-PC rule
// WAIT_STEP  | PC held; each step pulse grants one RUN-equivalent cycle
// DRAIN      | HALT seen, fetch off, in-flight instructions retire
// HALTED     | everything off until reset
module fetch_sequencer
  import dlx_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DLX_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = DLX_DATA_WIDTH,
  parameter logic [5:0]            HALT_OPCODE  = DLX_HALT_OPCODE,
  parameter int                    DRAIN_CYCLES = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  fetch_sequencer_if.master bus,
  output logic              halted,
  output logic [2:0]        state,
  output logic [31:0]       instr_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_plus_1;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  rd_valid;
  logic [31:0]           count_q;

  logic fetch_cycle;
  logic fetching_state;
  logic branch_go;
  logic jump_go;
  logic redirect;
  logic halt_det;
  logic hold;
  logic imem_en;
  logic pipe_en;
  logic flush;
  logic unused_instr_bits;

  assign pc_plus_1      = pc_q + ADDR_WIDTH'(1);
  assign fetching_state = (state_q == ST_RUN) || (state_q == ST_WAIT_STEP);
  assign fetch_cycle    = (state_q == ST_RUN) || ((state_q == ST_WAIT_STEP) && step);

  assign branch_go = fetch_cycle && bus.branch_taken;
  assign jump_go   = fetch_cycle && bus.jump_taken;
  assign redirect  = branch_go || jump_go;

  // rd_valid marks a word that was actually requested on the previous cycle.
  assign halt_det = fetching_state && rd_valid && !redirect &&
                    (bus.instruc_in[DATA_WIDTH-1 -: 6] == HALT_OPCODE);

  assign hold    = !fetch_cycle || bus.stall || halt_det;
  assign imem_en = fetch_cycle;
  assign pipe_en = fetch_cycle && !bus.stall;
  assign flush   = redirect || halt_det;

  assign unused_instr_bits = ^bus.instruc_in[DATA_WIDTH-7:0];

  next_pc_mux #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc_mux (
    .branch_taken   (branch_go),
    .branch_address (bus.branch_address),
    .jump_taken     (jump_go),
    .jump_address   (bus.jump_address),
    .hold           (hold),
    .pc             (pc_q),
    .pc_plus_1      (pc_plus_1),
    .pc_next        (pc_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = step_mode ? ST_WAIT_STEP : ST_RUN;
      end
      ST_RUN: begin
        if (halt_det)       state_d = ST_DRAIN;
        else if (step_mode) state_d = ST_WAIT_STEP;
      end
      ST_WAIT_STEP: begin
        if (halt_det)        state_d = ST_DRAIN;
        else if (!step_mode) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      drain_cnt <= '0;
      rd_valid  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= imem_en;

      if (state_q == ST_IDLE) pc_q <= RESET_PC;
      else                    pc_q <= pc_next;

      // Down-counter loaded on HALT; terminal count zero ends the drain.
      if (halt_det)
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
      else if ((state_q == ST_DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - DRAIN_W'(1);

      if (pipe_en && !flush && (count_q != '1))
        count_q <= count_q + 32'd1;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PC_plus_1   = pc_plus_1;
  assign bus.imem_enable = imem_en;
  assign bus.pipe_enable = pipe_en;
  assign bus.flush_IF_ID = flush;

  assign halted      = (state_q == ST_HALTED);
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table for run,
// stall, redirect, wrap and step control, then HALT-drain and step/reset runs.
module tb_fetch_sequencer;
  import dlx_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] instr_count;

  logic        halt_en;
  logic [9:0]  halt_pc;

  int n_chk;
  int n_fail;

  // ctl = {start, step_mode, step, stall, branch_taken, jump_taken}
  // en  = {pipe_enable, flush_IF_ID, imem_enable}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [9:0]  br_addr;
    logic [9:0]  jmp_addr;
    logic [9:0]  pc;
    logic [9:0]  pp1;
    logic [2:0]  en;
    logic [2:0]  st;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [23];

  fetch_sequencer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH   (10),
    .DATA_WIDTH   (32),
    .HALT_OPCODE  (6'b111111),
    .DRAIN_CYCLES (4),
    .RESET_PC     (10'h000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .bus         (bus),
    .halted      (halted),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory with one cycle of read latency; one word may hold HALT.
  always @(posedge clock or posedge reset) begin
    if (reset)
      bus.instruc_in <= DLX_NOP;
    else if (bus.imem_enable && halt_en && (bus.PC == halt_pc))
      bus.instruc_in <= {6'b111111, 26'h0};
    else
      bus.instruc_in <= DLX_NOP;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [9:0] ba, input logic [9:0] ja);
    {start, step_mode, step, bus.stall, bus.branch_taken, bus.jump_taken} = ctl;
    bus.branch_address = ba;
    bus.jump_address   = ja;
  endtask

  task automatic reset_dut();
    drive(6'b000000, 10'h000, 10'h000);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    halt_en = 1'b0;
    halt_pc = 10'h000;
    reset   = 1'b1;
    drive(6'b000000, 10'h000, 10'h000);

    vecs[0]  = '{6'b000000, 10'h000, 10'h000, 10'h000, 10'h001, 3'b000, 3'd0, 32'd0};
    vecs[1]  = '{6'b100000, 10'h000, 10'h000, 10'h000, 10'h001, 3'b000, 3'd0, 32'd0};
    vecs[2]  = '{6'b000000, 10'h000, 10'h000, 10'h000, 10'h001, 3'b101, 3'd1, 32'd0};
    vecs[3]  = '{6'b000000, 10'h000, 10'h000, 10'h001, 10'h002, 3'b101, 3'd1, 32'd1};
    vecs[4]  = '{6'b000000, 10'h000, 10'h000, 10'h002, 10'h003, 3'b101, 3'd1, 32'd2};
    vecs[5]  = '{6'b000000, 10'h000, 10'h000, 10'h003, 10'h004, 3'b101, 3'd1, 32'd3};
    vecs[6]  = '{6'b000000, 10'h000, 10'h000, 10'h004, 10'h005, 3'b101, 3'd1, 32'd4};
    vecs[7]  = '{6'b000100, 10'h000, 10'h000, 10'h005, 10'h006, 3'b001, 3'd1, 32'd5};
    vecs[8]  = '{6'b000100, 10'h000, 10'h000, 10'h005, 10'h006, 3'b001, 3'd1, 32'd5};
    vecs[9]  = '{6'b000000, 10'h000, 10'h000, 10'h005, 10'h006, 3'b101, 3'd1, 32'd5};
    vecs[10] = '{6'b000111, 10'h040, 10'h100, 10'h006, 10'h007, 3'b011, 3'd1, 32'd6};
    vecs[11] = '{6'b000000, 10'h000, 10'h000, 10'h040, 10'h041, 3'b101, 3'd1, 32'd6};
    vecs[12] = '{6'b000001, 10'h000, 10'h3FF, 10'h041, 10'h042, 3'b111, 3'd1, 32'd7};
    vecs[13] = '{6'b000000, 10'h000, 10'h000, 10'h3FF, 10'h000, 3'b101, 3'd1, 32'd7};
    vecs[14] = '{6'b000000, 10'h000, 10'h000, 10'h000, 10'h001, 3'b101, 3'd1, 32'd8};
    vecs[15] = '{6'b000101, 10'h000, 10'h010, 10'h001, 10'h002, 3'b011, 3'd1, 32'd9};
    vecs[16] = '{6'b010000, 10'h000, 10'h000, 10'h010, 10'h011, 3'b101, 3'd1, 32'd9};
    vecs[17] = '{6'b010000, 10'h000, 10'h000, 10'h011, 10'h012, 3'b000, 3'd2, 32'd10};
    vecs[18] = '{6'b011000, 10'h000, 10'h000, 10'h011, 10'h012, 3'b101, 3'd2, 32'd10};
    vecs[19] = '{6'b110000, 10'h000, 10'h000, 10'h012, 10'h013, 3'b000, 3'd2, 32'd11};
    vecs[20] = '{6'b000000, 10'h000, 10'h000, 10'h012, 10'h013, 3'b000, 3'd2, 32'd11};
    vecs[21] = '{6'b001000, 10'h000, 10'h000, 10'h012, 10'h013, 3'b101, 3'd1, 32'd11};
    vecs[22] = '{6'b000000, 10'h000, 10'h000, 10'h013, 10'h014, 3'b101, 3'd1, 32'd12};

    reset_dut();
    for (int i = 0; i < 23; i++) begin
      @(negedge clock);
      drive(vecs[i].ctl, vecs[i].br_addr, vecs[i].jmp_addr);
      #1;
      chk($sformatf("v%0d pc", i),     32'(bus.PC),          32'(vecs[i].pc));
      chk($sformatf("v%0d pc+1", i),   32'(bus.PC_plus_1),   32'(vecs[i].pp1));
      chk($sformatf("v%0d pipe_en", i), 32'(bus.pipe_enable), 32'(vecs[i].en[2]));
      chk($sformatf("v%0d flush", i),  32'(bus.flush_IF_ID), 32'(vecs[i].en[1]));
      chk($sformatf("v%0d imem_en", i), 32'(bus.imem_enable), 32'(vecs[i].en[0]));
      chk($sformatf("v%0d state", i),  32'(state),           32'(vecs[i].st));
      chk($sformatf("v%0d count", i),  instr_count,          vecs[i].cnt);
      chk($sformatf("v%0d halted", i), 32'(halted),          32'd0);
    end

    // HALT word at PC=7 arrives while PC=8; drain 4 cycles, then halt.
    halt_en = 1'b1;
    halt_pc = 10'h007;
    reset_dut();
    @(negedge clock);
    drive(6'b100000, 10'h000, 10'h000);
    @(negedge clock);
    drive(6'b000000, 10'h000, 10'h000);
    #1 chk("halt first pc", 32'(bus.PC), 32'h0);
    repeat (8) @(negedge clock);
    #1;
    chk("halt detect flush", 32'(bus.flush_IF_ID), 32'd1);
    chk("halt detect pc",    32'(bus.PC),          32'h008);
    chk("halt detect state", 32'(state),           32'(ST_RUN));
    @(negedge clock);
    drive(6'b000010, 10'h040, 10'h000);
    #1;
    chk("drain0 state", 32'(state),           32'(ST_DRAIN));
    chk("drain0 imem",  32'(bus.imem_enable), 32'd0);
    chk("drain0 flush", 32'(bus.flush_IF_ID), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      drive(6'b000000, 10'h000, 10'h000);
      #1;
      chk($sformatf("drain%0d state", k),  32'(state),  32'(ST_DRAIN));
      chk($sformatf("drain%0d halted", k), 32'(halted), 32'd0);
      chk($sformatf("drain%0d pc", k),     32'(bus.PC), 32'h008);
    end
    @(negedge clock);
    drive(6'b100000, 10'h000, 10'h000);
    #1;
    chk("halted flag",  32'(halted),          32'd1);
    chk("halted state", 32'(state),           32'(ST_HALTED));
    chk("halted imem",  32'(bus.imem_enable), 32'd0);
    chk("halted pipe",  32'(bus.pipe_enable), 32'd0);
    chk("halted count", instr_count,          32'd8);
    @(negedge clock);
    drive(6'b000000, 10'h000, 10'h000);
    #1;
    chk("halted ignores start", 32'(state),  32'(ST_HALTED));
    chk("halted pc frozen",     32'(bus.PC), 32'h008);

    // Single-step: one PC advance per pulse, pulses 5 cycles apart.
    halt_en = 1'b0;
    reset_dut();
    @(negedge clock);
    drive(6'b110000, 10'h000, 10'h000);
    @(negedge clock);
    drive(6'b010000, 10'h000, 10'h000);
    #1;
    chk("step wait state", 32'(state),           32'(ST_WAIT_STEP));
    chk("step wait pipe",  32'(bus.pipe_enable), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      drive(6'b011000, 10'h000, 10'h000);
      #1 chk($sformatf("step%0d pipe", k), 32'(bus.pipe_enable), 32'd1);
      @(negedge clock);
      drive(6'b010000, 10'h000, 10'h000);
      #1;
      chk($sformatf("step%0d pc", k),    32'(bus.PC), 32'(k));
      chk($sformatf("step%0d state", k), 32'(state),  32'(ST_WAIT_STEP));
      repeat (3) @(negedge clock);
      #1 chk($sformatf("step%0d hold", k), 32'(bus.PC), 32'(k));
    end
    chk("step count", instr_count, 32'd3);

    // Asynchronous reset between clock edges takes effect at once.
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async rst state", 32'(state),         32'(ST_IDLE));
    chk("async rst pc",    32'(bus.PC),        32'h000);
    chk("async rst pc+1",  32'(bus.PC_plus_1), 32'h001);
    chk("async rst count", instr_count,        32'd0);
    chk("async rst imem",  32'(bus.imem_enable), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
